// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and action encoding for the up/down modulo counter.
// The action helper keeps the reset > load > count > hold priority in one place.
package updown_mod_counter_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MAX_VAL = 9;

  typedef enum logic [1:0] {
    ACT_RESET = 2'd0,
    ACT_LOAD  = 2'd1,
    ACT_COUNT = 2'd2,
    ACT_HOLD  = 2'd3
  } action_e;

  function automatic action_e select_action(input logic reset, input logic load,
                                            input logic en);
    if (reset)     return ACT_RESET;
    else if (load) return ACT_LOAD;
    else if (en)   return ACT_COUNT;
    else           return ACT_HOLD;
  endfunction

endpackage

// File: rtl/updown_mod_counter_step.sv
// Combinational step logic: next count value, wrap detection, terminal count
// and clamped load value. Holds no state; the registers live in the top.
module counter_step
  import updown_mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MAX_VAL = DEFAULT_MAX_VAL
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic             up_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_next_o,
  output logic [WIDTH-1:0] load_next_o,
  output logic             wrap_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic atLimit;

  // A count step wraps when it would leave the 0..MAX_VAL range in the chosen direction.
  always_comb begin
    atLimit      = up_i ? (cur_i == MAX) : (cur_i == ZERO);
    count_next_o = cur_i;
    if (up_i) begin
      count_next_o = atLimit ? ZERO : (cur_i + ONE);
    end else begin
      count_next_o = atLimit ? MAX : (cur_i - ONE);
    end
    load_next_o = (load_val_i > MAX) ? MAX : load_val_i;
    wrap_o      = atLimit;
    tc_o        = en_i & ~load_i & atLimit;
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter (0..MAX_VAL) with clamped parallel load, one-cycle
// wrap pulse and a sticky overflow flag. Synchronous active-high reset.
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MAX_VAL = DEFAULT_MAX_VAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Reject widths or limits that cannot be represented by the counter.
  if (WIDTH < 2 || WIDTH > 32 || MAX_VAL < 1 ||
      longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : gBadParams
    $error("updown_mod_counter: illegal WIDTH/MAX_VAL combination");
  end

  action_e          action;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] stepCur;
  logic [WIDTH-1:0] countNext;
  logic [WIDTH-1:0] loadNext;
  logic             stepWrap;
  logic             stepTc;

  // While reset is asserted tc is evaluated as if the count were already zero.
  always_comb begin
    action  = select_action(reset, load, en);
    stepCur = (action == ACT_RESET) ? '0 : cnt_q;
  end

  counter_step #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_step (
    .cur_i        (stepCur),
    .up_i         (up),
    .en_i         (en),
    .load_i       (load),
    .load_val_i   (load_val),
    .count_next_o (countNext),
    .load_next_o  (loadNext),
    .wrap_o       (stepWrap),
    .tc_o         (stepTc)
  );

  // A wrap on the same edge as clr_ovf still sets the flag: set beats clear.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q & ~clr_ovf;
    unique case (action)
      ACT_RESET: begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      ACT_LOAD: cnt_d = loadNext;
      ACT_COUNT: begin
        cnt_d  = countNext;
        wrap_d = stepWrap;
        ovf_d  = ovf_d | stepWrap;
      end
      ACT_HOLD: cnt_d = cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q    = cnt_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;
  assign tc   = stepTc;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed self-checking bench for updown_mod_counter (WIDTH=4, MAX_VAL=9),
// expected values hand-computed for each step.
module tb_updown_mod_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic       clr_ovf;
  logic [3:0] q;
  logic       tc;
  logic       wrap;
  logic       ovf;

  int testsRun;
  int testsFailed;

  updown_mod_counter #(
    .WIDTH   (4),
    .MAX_VAL (9)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .clr_ovf  (clr_ovf),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all inputs, then let combinational outputs settle before any check.
  task automatic applyStimulus(input logic r, input logic ld, input logic [3:0] lv,
                               input logic e, input logic u, input logic c);
    reset    = r;
    load     = ld;
    load_val = lv;
    en       = e;
    up       = u;
    clr_ovf  = c;
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [3:0] expQ,
                            input logic expWrap, input logic expOvf);
    checkOutput({tag, ".q"}, 32'(q), 32'(expQ));
    checkOutput({tag, ".wrap"}, 32'(wrap), 32'(expWrap));
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expOvf));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    // Reset for 100 ns while counting up is requested
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("reset.tc_up", 32'(tc), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      checkState("reset.hold", 4'd0, 1'b0, 1'b0);
    end

    // Count 1..9 then wrap to 0
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      cycle();
      checkOutput("up.q", 32'(q), 32'(i));
    end
    checkOutput("up.tc_at9", 32'(tc), 32'd1);
    cycle();
    checkState("up.wrap", 4'd0, 1'b1, 1'b1);
    cycle();
    checkState("up.after", 4'd1, 1'b0, 1'b1);

    // Clear sticky flag while holding
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    cycle();
    checkState("clr", 4'd1, 1'b0, 1'b0);

    // Down-count wrap from 2
    applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    cycle();
    checkState("down.load", 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("down.tc_at2", 32'(tc), 32'd0);
    cycle();
    checkOutput("down.q1", 32'(q), 32'd1);
    cycle();
    checkOutput("down.q0", 32'(q), 32'd0);
    checkOutput("down.tc_at0", 32'(tc), 32'd1);
    cycle();
    checkState("down.wrap", 4'd9, 1'b1, 1'b1);
    cycle();
    checkState("down.q8", 4'd8, 1'b0, 1'b1);

    // Clear flag, then load clamp 15 -> 9
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    cycle();
    checkState("clr2", 4'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    cycle();
    checkState("clamp", 4'd9, 1'b0, 1'b0);

    // Load at q=9 with en/up set: load wins, no wrap
    applyStimulus(1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    checkOutput("loadtc.tc", 32'(tc), 32'd0);
    cycle();
    checkState("loadtc", 4'd3, 1'b0, 1'b0);

    // clr_ovf on the same edge as a 9->0 wrap: set wins
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    cycle();
    checkState("setwins", 4'd0, 1'b1, 1'b1);

    // Direction toggling from 5
    applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("dir.q5", 32'(q), 32'd5);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    cycle();
    checkOutput("dir.q6a", 32'(q), 32'd6);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    checkOutput("dir.q5a", 32'(q), 32'd5);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    cycle();
    checkOutput("dir.q6b", 32'(q), 32'd6);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    checkOutput("dir.q5b", 32'(q), 32'd5);

    // Hold for three cycles
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold.tc", 32'(tc), 32'd0);
      cycle();
      checkState("hold", 4'd5, 1'b0, 1'b1);
    end

    // Reset mid-count at q=7 with load asserted
    applyStimulus(1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    cycle();
    checkOutput("mid.q7", 32'(q), 32'd7);
    applyStimulus(1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    cycle();
    checkState("mid.reset", 4'd0, 1'b0, 1'b0);

    // tc during reset uses q=0: counting down would wrap
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset.tc_down", 32'(tc), 32'd1);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    cycle();
    checkState("resume", 4'd1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH SHALL default to 4 and set the counter width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL SHALL default to 9 and set the upper count limit; legal range 1..(2^WIDTH)-1, enforced by an elaboration-time check.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port en SHALL be an input, 1 bit: count enable.
REQ-006 Port up SHALL be an input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-007 Port load SHALL be an input, 1 bit: synchronous parallel-load strobe.
REQ-008 Port load_val SHALL be an input, WIDTH bits: the value to load.
REQ-009 Port clr_ovf SHALL be an input, 1 bit: clears the sticky wrap flag.
REQ-010 Port q SHALL be an output, WIDTH bits: registered count value.
REQ-011 Port tc SHALL be an output, 1 bit: combinational terminal count; high when en=1 and the next enabled step wraps.
REQ-012 Port wrap SHALL be an output, 1 bit: registered one-cycle pulse following a wrap.
REQ-013 Port ovf SHALL be an output, 1 bit: sticky wrap-occurred flag.

Function
REQ-014 Each clock edge SHALL apply one action, in priority order: reset > load > en-count > hold.
REQ-015 Load: q SHALL take load_val on the next edge; load_val > MAX_VAL SHALL clamp to MAX_VAL. Load SHALL ignore en and up.
REQ-016 Count up: q < MAX_VAL -> q+1; q == MAX_VAL -> 0, a wrap event.
REQ-017 Count down: q > 0 -> q-1; q == 0 -> MAX_VAL, a wrap event.
REQ-018 Hold: en=0 and load=0 SHALL leave q, ovf unchanged; wrap SHALL be 0.
REQ-019 tc SHALL be en & ~load & (up ? q==MAX_VAL : q==0), with zero register latency.
REQ-020 wrap SHALL be 1 for exactly the one cycle after an edge on which a wrap event occurred, else 0.
REQ-021 ovf SHALL set on the edge of any wrap event and stay set until reset or clr_ovf.
REQ-022 When clr_ovf and a wrap event occur on the same edge, set SHALL win: ovf=1.
REQ-023 A direction change SHALL take effect on the same edge it is sampled; no dead cycle.
REQ-024 A load coinciding with tc=1 SHALL produce no wrap event; wrap stays 0 and ovf is unchanged.
REQ-025 All arithmetic SHALL be WIDTH bits with explicit compares; q SHALL never exceed MAX_VAL.

Reset
REQ-026 On a clock edge with reset=1: q=0, wrap=0, ovf=0, overriding load, en and clr_ovf.
REQ-027 Reset asserted mid-count SHALL take effect on the next edge; counting resumes from 0 on the first edge after deassertion.
REQ-028 During reset, tc SHALL follow REQ-019 using q=0.

Structure
REQ-029 A shared package SHALL hold the default WIDTH/MAX_VAL constants and the action-select encoding (RESET, LOAD, COUNT, HOLD).
REQ-030 Next-value/wrap-detect logic SHALL be one combinational sub-module, counter_step, instantiated once; registers stay in updown_mod_counter.

Verification (WIDTH=4, MAX_VAL=9, clk period 10 ns)
REQ-031 Reset
- Stimulus: reset=1 for 100 ns, then 0; en=1, up=1.
- Required: q=0 during reset, then 1,2,...,9,0; wrap pulses once after 9->0; ovf=1 thereafter.
REQ-032 Down-count wrap
- Stimulus: load 2, then en=1, up=0.
- Required: q sequence 2,1,0,9,8; tc=1 while q=0; wrap=1 in the cycle q=9.
REQ-033 Load clamp
- Stimulus: load=1, load_val=15.
- Required: q=9 next cycle.
- Stimulus: load=1 with en=1, up=1 and q=9.
- Required: q=load_val, wrap=0.
REQ-034 Sticky flag
- Stimulus: after a wrap, clr_ovf=1 for one cycle.
- Required: ovf=0.
- Stimulus: clr_ovf=1 on the same edge as a 9->0 wrap.
- Required: ovf=1.
REQ-035 Direction and hold
- Stimulus: from q=5, up toggles each cycle with en=1.
- Required: q alternates 6,5,6,5.
- Stimulus: en=0 for 3 cycles.
- Required: q held, tc=0.
REQ-036 Reset mid-operation
- Stimulus: reset=1 at q=7 while counting, together with clr_ovf=0 and load=1.
- Required: q=0, ovf=0, wrap=0 next edge.
